// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory with a valid/ready request and a one-cycle response.
// Byte/half/word loads and stores, little-endian, with sign/zero extension.
// Faults on misalignment, out-of-range access or illegal size. A faulting
// request writes nothing and still takes the full access latency.
//
// state | meaning
// IDLE  | ready for a request, no response pending
// WAIT  | request latched, counting down the access latency
// RESP  | response valid this cycle, a new request may be accepted
module data_mem_ctrl #(
   parameter int XLEN        = 32,
   parameter int DEPTH_BYTES = 128,
   parameter int LATENCY     = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_fault,
   output logic            busy
);

   localparam int AW = $clog2(DEPTH_BYTES);
   localparam logic [XLEN:0] DEPTH_W = (XLEN+1)'(DEPTH_BYTES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic [1:0]      cnt_q;
   logic            we_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [1:0]      size_q;
   logic            unsigned_q;
   logic [7:0]      mem [DEPTH_BYTES];

   logic            accept;
   logic            access;
   logic [2:0]      nbytes;
   logic [XLEN:0]   end_addr;
   logic            fault;
   logic [AW-1:0]   idx;
   logic [7:0]      rb [4];
   logic [XLEN-1:0] load_ext;

   assign accept = req_valid && req_ready;

   // Next-state and handshake outputs decoded from the current state.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      busy      = 1'b0;
      rsp_valid = 1'b0;
      access    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (cnt_q == 2'd0) begin
               access  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            req_ready = 1'b1;
            state_d   = req_valid ? WAIT : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Fault detection and load data assembly from the latched request.
   // The range check is one bit wider than the address so it cannot wrap.
   always_comb begin
      case (size_q)
         2'b00:   nbytes = 3'd1;
         2'b01:   nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
      end_addr = {1'b0, addr_q} + {{(XLEN-2){1'b0}}, nbytes};
      fault = (size_q == 2'b11)
           || (size_q == 2'b01 && addr_q[0])
           || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
           || (end_addr > DEPTH_W);
      idx = addr_q[AW-1:0];
      for (int k = 0; k < 4; k++) rb[k] = mem[idx + AW'(k)];
      case (size_q)
         2'b00:   load_ext = unsigned_q ? {{(XLEN-8){1'b0}}, rb[0]}
                                        : {{(XLEN-8){rb[0][7]}}, rb[0]};
         2'b01:   load_ext = unsigned_q ? {{(XLEN-16){1'b0}}, rb[1], rb[0]}
                                        : {{(XLEN-16){rb[1][7]}}, rb[1], rb[0]};
         default: load_ext = {rb[3], rb[2], rb[1], rb[0]};
      endcase
   end

   // State, latency down-counter, request latch and response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         rsp_rdata  <= '0;
         rsp_fault  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q      <= 2'(LATENCY - 1);
            we_q       <= req_we;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
         end else if (state_q == WAIT && cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
         end
         if (access) begin
            rsp_fault <= fault;
            rsp_rdata <= (fault || we_q) ? '0 : load_ext;
         end
      end
   end

   // Byte storage: cleared on reset, written only by a non-faulting store.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'h00;
      end else if (access && we_q && !fault) begin
         for (int k = 0; k < 4; k++)
            if (3'(k) < nbytes) mem[idx + AW'(k)] <= wdata_q[8*k +: 8];
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a LATENCY=1 instance driven from a vector table
// with a response scoreboard, and a LATENCY=3 instance for streaming timing.
module tb_data_mem_ctrl;

   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   logic        clk = 1'b0;
   logic        reset;

   logic        a_valid, a_ready, a_we, a_uns, a_rsp_valid, a_fault, a_busy;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic [1:0]  a_size;

   logic        b_valid, b_ready, b_we, b_uns, b_rsp_valid, b_fault, b_busy;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic [1:0]  b_size;

   always #5 clk = ~clk;

   data_mem_ctrl #(.XLEN(32), .DEPTH_BYTES(128), .LATENCY(LAT_A)) dut_a (
      .clk(clk), .reset(reset),
      .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
      .req_addr(a_addr), .req_wdata(a_wdata), .req_size(a_size),
      .req_unsigned(a_uns), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata),
      .rsp_fault(a_fault), .busy(a_busy)
   );

   data_mem_ctrl #(.XLEN(32), .DEPTH_BYTES(128), .LATENCY(LAT_B)) dut_b (
      .clk(clk), .reset(reset),
      .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
      .req_addr(b_addr), .req_wdata(b_wdata), .req_size(b_size),
      .req_unsigned(b_uns), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
      .rsp_fault(b_fault), .busy(b_busy)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] exp_rdata;
      logic        exp_fault;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          cyc;
   } exp_t;

   vec_t  vecs[$];
   exp_t  sb[$];
   int    pass_cnt = 0;
   int    chk_cnt  = 0;
   int    cyc      = 0;
   bit    mon_en   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Scoreboard: every response must match the oldest outstanding request.
   always @(negedge clk) begin
      if (mon_en && a_rsp_valid) begin
         if (sb.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_rdata", a_rdata, e.rdata);
            check("rsp_fault", {31'b0, a_fault}, {31'b0, e.fault});
            check("rsp_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic issue(input vec_t v, input bit push);
      int n;
      @(negedge clk);
      a_valid = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
      a_size = v.size; a_uns = v.uns;
      n = 0;
      while (!a_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!a_ready) begin
         chk_cnt++;
         $display("FAIL ready_timeout: req_ready stayed 0 for %0d cycles", n);
         a_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (push) begin
         exp_t e;
         e.rdata = v.exp_rdata; e.fault = v.exp_fault; e.cyc = cyc + LAT_A;
         sb.push_back(e);
      end
      check("busy_after_accept", {31'b0, a_busy}, 32'd1);
      a_valid = 1'b0;
      a_addr  = 32'hXXXX_XXXX;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk_cnt++;
         $display("FAIL drain_timeout: %0d responses still outstanding", sb.size());
      end
      @(negedge clk);
   endtask

   function automatic vec_t mk(input logic we, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [1:0] size,
                               input logic uns, input logic [31:0] er,
                               input logic ef);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wd; v.size = size; v.uns = uns;
      v.exp_rdata = er; v.exp_fault = ef;
      return v;
   endfunction

   initial begin
      int last_acc, low_run, pulses;
      bit prev_rsp;

      vecs.push_back(mk(1, 32'h14, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0));
      vecs.push_back(mk(0, 32'h14, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0));
      vecs.push_back(mk(1, 32'h15, 32'h12345680, 2'b00, 0, 32'h0, 0));
      vecs.push_back(mk(0, 32'h15, 32'h0,        2'b00, 0, 32'hFFFFFF80, 0));
      vecs.push_back(mk(0, 32'h15, 32'h0,        2'b00, 1, 32'h00000080, 0));
      vecs.push_back(mk(0, 32'h14, 32'h0,        2'b10, 0, 32'hDEAD80EF, 0));
      vecs.push_back(mk(0, 32'h13, 32'h0,        2'b01, 0, 32'h0, 1));
      vecs.push_back(mk(1, 32'h16, 32'h55555555, 2'b10, 0, 32'h0, 1));
      vecs.push_back(mk(0, 32'h14, 32'h0,        2'b10, 1, 32'hDEAD80EF, 0));
      vecs.push_back(mk(0, 32'h16, 32'h0,        2'b01, 0, 32'hFFFFDEAD, 0));
      vecs.push_back(mk(0, 32'h14, 32'h0,        2'b01, 1, 32'h000080EF, 0));
      vecs.push_back(mk(0, 32'h14, 32'h0,        2'b11, 0, 32'h0, 1));
      vecs.push_back(mk(1, 32'h7C, 32'h11223344, 2'b10, 0, 32'h0, 0));
      vecs.push_back(mk(0, 32'h7C, 32'h0,        2'b10, 0, 32'h11223344, 0));
      vecs.push_back(mk(0, 32'h80, 32'h0,        2'b10, 0, 32'h0, 1));
      vecs.push_back(mk(0, 32'hFFFFFFFC, 32'h0,  2'b10, 0, 32'h0, 1));
      vecs.push_back(mk(1, 32'hFFFFFFFC, 32'hCAFEF00D, 2'b10, 0, 32'h0, 1));
      vecs.push_back(mk(0, 32'h0,  32'h0,        2'b10, 0, 32'h0, 0));
      vecs.push_back(mk(0, 32'h7F, 32'h0,        2'b00, 0, 32'h00000011, 0));
      vecs.push_back(mk(0, 32'h7F, 32'h0,        2'b00, 1, 32'h00000011, 0));
      vecs.push_back(mk(0, 32'h7F, 32'h0,        2'b01, 1, 32'h0, 1));
      vecs.push_back(mk(0, 32'h80, 32'h0,        2'b00, 0, 32'h0, 1));
      vecs.push_back(mk(0, 32'h7E, 32'h0,        2'b01, 0, 32'h00001122, 0));

      reset = 1'b1;
      a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_size = 2'b00; a_uns = 1'b0;
      b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_size = 2'b10; b_uns = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_req_ready", {31'b0, a_ready}, 32'd1);
      check("reset_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
      check("reset_rsp_rdata", a_rdata, 32'd0);
      check("reset_rsp_fault", {31'b0, a_fault}, 32'd0);
      check("reset_busy", {31'b0, a_busy}, 32'd0);
      check("reset_b_ready", {31'b0, b_ready}, 32'd1);
      reset = 1'b0;
      mon_en = 1'b1;

      foreach (vecs[i]) issue(vecs[i], 1'b1);
      drain();

      // Response data and fault hold after rsp_valid drops.
      issue(mk(0, 32'h7C, 32'h0, 2'b10, 0, 32'h11223344, 0), 1'b1);
      drain();
      repeat (3) @(negedge clk);
      check("hold_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
      check("hold_rsp_rdata", a_rdata, 32'h11223344);
      check("hold_rsp_fault", {31'b0, a_fault}, 32'd0);

      // Reset while a store sits in WAIT: no response, memory cleared.
      issue(mk(1, 32'h20, 32'hA5A5A5A5, 2'b10, 0, 32'h0, 0), 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_ready", {31'b0, a_ready}, 32'd1);
      check("post_reset_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
      check("post_reset_busy", {31'b0, a_busy}, 32'd0);
      check("post_reset_rdata", a_rdata, 32'd0);
      issue(mk(0, 32'h20, 32'h0, 2'b10, 0, 32'h0, 0), 1'b1);
      issue(mk(0, 32'h14, 32'h0, 2'b10, 0, 32'h0, 0), 1'b1);
      issue(mk(0, 32'h7C, 32'h0, 2'b10, 0, 32'h0, 0), 1'b1);
      drain();

      // LATENCY=3 streaming with req_valid held high.
      @(negedge clk);
      b_valid = 1'b1;
      last_acc = -1; low_run = 0; pulses = 0; prev_rsp = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (b_ready) begin
            if (last_acc >= 0) check("b_accept_interval", 32'(i - last_acc), 32'(LAT_B + 1));
            if (low_run > 0) check("b_ready_low_run", 32'(low_run), 32'(LAT_B));
            last_acc = i;
            low_run = 0;
         end else begin
            low_run++;
         end
         if (b_rsp_valid) begin
            pulses++;
            check("b_pulse_width", {31'b0, prev_rsp}, 32'd0);
         end
         prev_rsp = b_rsp_valid;
         @(negedge clk);
      end
      b_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (b_rsp_valid) begin
            pulses++;
            check("b_pulse_width", {31'b0, prev_rsp}, 32'd0);
         end
         prev_rsp = b_rsp_valid;
         @(negedge clk);
      end
      check("b_pulse_count", 32'(pulses), 32'd4);
      check("b_idle_ready", {31'b0, b_ready}, 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
